xbar_forward_arbiter: RTL and testbench

//  Per-slave arbiter for one forward channel (AR or AW) of the crossbar; one instance per slave per channel.

---
 rtl/xbar_forward_arbiter.sv | 147 ++++++++++++++
 tb/tb_xbar_forward_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/xbar_forward_arbiter.sv
// Per-slave round-robin arbiter for one crossbar forward channel (AR or AW).
// Optionally tracks the order of granted masters so W beats can be steered.
module xbar_forward_arbiter #(
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0,
  parameter int ORDER_EN          = 0,
  parameter int ORDER_DEPTH       = 4,
  localparam int MW = (masters > 1) ? $clog2(masters) : 1,
  localparam int SW = (slaves > 1) ? $clog2(slaves) : 1,
  localparam int GW = MW + 1
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [0:masters-1]           master_fifo_empty,
  input  logic [0:masters-1][SW-1:0]   master_dest_slave,
  input  logic                         slave_fifo_full,
  output logic [GW-1:0]                grant_master_number,
  output logic                         push_to_fifo,
  input  logic                         order_pop,
  output logic [MW-1:0]                order_master,
  output logic                         order_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [MW-1:0]    last_grant;
  logic [0:masters-1] req;
  logic [MW-1:0]    win;
  logic             win_ok;
  logic             xfer;
  logic             order_full;
  logic [MW-1:0]    cur;
  int               idx;

  always_comb begin
    for (int m = 0; m < masters; m++) begin
      req[m] = ~master_fifo_empty[m] &
               (master_dest_slave[m] == SW'(i_am_slave_number));
    end
  end

  // search starts one past the last master that actually transferred
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    for (int k = 1; k <= masters; k++) begin
      idx = (int'(last_grant) + k) % masters;
      if (!win_ok && req[idx]) begin
        win    = MW'(idx);
        win_ok = 1'b1;
      end
    end
  end

  assign cur  = grant_master_number[MW-1:0];
  assign xfer = push_to_fifo & ~slave_fifo_full;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state               <= IDLE;
      grant_master_number <= '1;
      push_to_fifo        <= 1'b0;
      last_grant          <= MW'(masters - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (win_ok && !order_full) begin
            grant_master_number <= {1'b0, win};
            push_to_fifo        <= 1'b1;
            state               <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            last_grant          <= cur;
            grant_master_number <= '1;
            push_to_fifo        <= 1'b0;
            state               <= GAP;
          end else if (!req[cur]) begin
            grant_master_number <= '1;
            push_to_fifo        <= 1'b0;
            state               <= IDLE;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  generate
    if (ORDER_EN != 0) begin : g_order
      localparam int PW = $clog2(ORDER_DEPTH);

      logic [MW-1:0] mem [ORDER_DEPTH];
      logic [PW:0]   wr_ptr;
      logic [PW:0]   rd_ptr;
      logic [PW:0]   cnt;
      logic          do_pop;

      assign cnt        = wr_ptr - rd_ptr;
      assign order_full = (cnt == (PW + 1)'(ORDER_DEPTH));
      assign order_valid = (cnt != '0);
      assign do_pop     = order_pop & order_valid;
      assign order_master = order_valid ? mem[wr_ptr[PW-1:0] - wr_ptr[PW-1:0] + rd_ptr[PW-1:0]] : '0;

      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (xfer) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end

      always_ff @(posedge ACLK) begin
        if (xfer) begin
          mem[wr_ptr[PW-1:0]] <= cur;
        end
      end
    end else begin : g_no_order
      logic unused_order_pop;

      assign unused_order_pop = order_pop;
      assign order_full       = 1'b0;
      assign order_valid      = 1'b0;
      assign order_master     = '0;
    end
  endgenerate

endmodule

// File: tb/tb_xbar_forward_arbiter.sv
// Randomized and directed bench for xbar_forward_arbiter with an order queue.
// A queue-based transaction model predicts every output each cycle.
module tb_xbar_forward_arbiter;

  localparam int M  = 2;
  localparam int S  = 2;
  localparam int ME = 0;
  localparam int OD = 2;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [0:M-1]      master_fifo_empty;
  logic [0:M-1][0:0] master_dest_slave;
  logic              slave_fifo_full;
  logic              order_pop;
  logic [1:0]        grant_master_number;
  logic              push_to_fifo;
  logic [0:0]        order_master;
  logic              order_valid;

  int n_tests = 0;
  int n_fail  = 0;

  int cur;
  int last;
  bit gap;
  int q[$];

  always #5 ACLK = ~ACLK;

  xbar_forward_arbiter #(
    .masters(M),
    .slaves(S),
    .i_am_slave_number(ME),
    .ORDER_EN(1),
    .ORDER_DEPTH(OD)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .master_fifo_empty(master_fifo_empty),
    .master_dest_slave(master_dest_slave),
    .slave_fifo_full(slave_fifo_full),
    .grant_master_number(grant_master_number),
    .push_to_fifo(push_to_fifo),
    .order_pop(order_pop),
    .order_master(order_master),
    .order_valid(order_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit mreq(int m);
    return !master_fifo_empty[m] && (int'(master_dest_slave[m]) == ME);
  endfunction

  // one clock of the arbiter, expressed as a transaction-level rule set
  task automatic model_step();
    int sz;
    bit found;
    int c;
    sz = q.size();
    if (ARESET) begin
      cur = -1;
      last = M - 1;
      gap = 0;
      q.delete();
      return;
    end
    if (order_pop && sz > 0) void'(q.pop_front());
    if (cur >= 0) begin
      if (!slave_fifo_full) begin
        q.push_back(cur);
        last = cur;
        cur = -1;
        gap = 1;
      end else if (!mreq(cur)) begin
        cur = -1;
      end
    end else if (gap) begin
      gap = 0;
    end else if (sz < OD) begin
      found = 0;
      for (int k = 1; k <= M; k++) begin
        c = (last + k) % M;
        if (!found && mreq(c)) begin
          cur = c;
          found = 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input logic [0:M-1] emp,
                       input logic [0:M-1][0:0] dst,
                       input bit full, input bit pop);
    ARESET = rst;
    master_fifo_empty = emp;
    master_dest_slave = dst;
    slave_fifo_full = full;
    order_pop = pop;
    @(posedge ACLK);
    model_step();
    #1;
    chk("grant", grant_master_number, (cur < 0) ? 32'd3 : 32'(cur));
    chk("push", push_to_fifo, (cur < 0) ? 32'd0 : 32'd1);
    chk("ovalid", order_valid, (q.size() != 0) ? 32'd1 : 32'd0);
    chk("omaster", order_master, (q.size() != 0) ? 32'(q[0]) : 32'd0);
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    cycle(1, 2'b11, 2'b00, 0, 0);
    cycle(1, 2'b11, 2'b00, 0, 0);
  endtask

  initial begin
    int g[$];
    bit r;
    logic [0:M-1] e;
    logic [0:M-1][0:0] d;
    cur = -1;
    last = M - 1;
    gap = 0;
    @(negedge ACLK);
    do_reset();
    chk("rst_grant", grant_master_number, 32'd3);
    chk("rst_push", push_to_fifo, 32'd0);

    // only master1 requests
    cycle(0, 2'b10, 2'b00, 0, 1);
    chk("t1_grant", grant_master_number, 32'd1);
    cycle(0, 2'b10, 2'b00, 0, 1);
    chk("t1_after", push_to_fifo, 32'd0);
    cycle(0, 2'b10, 2'b00, 0, 1);
    cycle(0, 2'b11, 2'b00, 0, 1);

    // both request continuously: strict alternation
    do_reset();
    g.delete();
    for (int i = 0; i < 14; i++) begin
      cycle(0, 2'b00, 2'b00, 0, 1);
      if (push_to_fifo) g.push_back(int'(grant_master_number));
    end
    for (int i = 0; i < 4; i++) chk("t2_seq", g[i], i % 2);

    // backpressure holds grant
    do_reset();
    cycle(0, 2'b00, 2'b00, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 2'b00, 2'b00, 1, 1);
      chk("t3_hold", grant_master_number, 32'd0);
    end
    cycle(0, 2'b00, 2'b00, 0, 1);
    cycle(0, 2'b00, 2'b00, 0, 1);
    cycle(0, 2'b00, 2'b00, 0, 1);
    chk("t3_next", grant_master_number, 32'd1);

    // request for another slave is ignored
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(0, 2'b01, 2'b10, 0, 1);
      chk("t4_nopush", push_to_fifo, 32'd0);
    end

    // order queue fills and blocks
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 2'b00, 2'b00, 0, 0);
    chk("t5_omaster", order_master, 32'd0);
    chk("t5_blocked", push_to_fifo, 32'd0);
    cycle(0, 2'b00, 2'b00, 0, 1);
    chk("t5_popped", order_master, 32'd1);
    cycle(0, 2'b00, 2'b00, 0, 0);
    chk("t5_third", push_to_fifo, 32'd1);

    // reset in the middle of a grant
    do_reset();
    cycle(0, 2'b00, 2'b00, 1, 0);
    cycle(1, 2'b00, 2'b00, 1, 0);
    chk("t6_grant", grant_master_number, 32'd3);
    chk("t6_ovalid", order_valid, 32'd0);
    cycle(0, 2'b00, 2'b00, 0, 0);
    chk("t6_first", grant_master_number, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 49) == 0);
      e = M'($urandom);
      d = M'($urandom);
      cycle(r, e, d, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
